mem_access_sequencer: RTL and testbench
=======================================

# mem_access_sequencer

Parametrised data-port sequencer for the memory stage of the pipelined LC-3b core. It accepts one memory operation per handshake from the memory-stage register and drives data port b. Supported operations are word or byte load/store and 0..MAX_INDIRECT levels of pointer indirection (LDI/STI generalised). It replaces the toggle-based LDI/STI stall scheme with an explicit FSM, adds flush and a saturating stall-cycle counter, and holds results until the write-back stage accepts them.

## Interface
Parameters:
- DATA_W, 16: data and address width; must be even and at least 16.
- MAX_INDIRECT, 1: maximum pointer-fetch levels per request; must be at least 1.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  byte access (LDB/STB).
- req_levels  in  $clog2(MAX_INDIRECT+1)  number of pointer fetches before the final access.
- req_addr  in  DATA_W  effective address.
- req_wdata  in  DATA_W  store data; for byte stores only bits [7:0] are used.
- flush  in  1  kill the in-flight request.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  write-back stage accepts the result.
- rsp_rdata  out  DATA_W  load data; byte loads are zero-extended.
- rsp_addr  out  DATA_W  final access address after indirection.
- mem_read, mem_write  out  1  data-port strobes.
- mem_wmask  out  2  byte-lane enables; bit 1 = high byte.
- mem_address, mem_wdata  out  DATA_W  data-port address and write data.
- mem_resp  in  1  data-port completion.
- mem_rdata  in  DATA_W  data-port read data.
- stall_cycles  out  CNT_W  saturating count of cycles spent in PTR or ACCESS.

## Operation
- States: IDLE, PTR, ACCESS, RESP.
- IDLE: req_ready=1. When req_valid=1, latch the request, set remaining = min(req_levels, MAX_INDIRECT), and go to PTR if remaining>0, otherwise to ACCESS.
- PTR: mem_read=1, mem_wmask=2'b11, mem_address = current address with bit 0 cleared.
  - On mem_resp: current address ← mem_rdata and remaining decrements.
  - When remaining reaches 0, go to ACCESS; otherwise stay in PTR and issue the next read on the following cycle.
- ACCESS, word access: mem_address has bit 0 cleared; mem_wmask=2'b11; mem_wdata=req_wdata.
- ACCESS, byte access: mem_address is unmodified. mem_wmask = addr[0] ? 2'b10 : 2'b01. mem_wdata = {wdata[7:0], wdata[7:0]}.
- ACCESS, strobes: mem_read=!write, mem_write=write.
- ACCESS, completion: on mem_resp, capture rsp_rdata and rsp_addr, then go to RESP.
  - Word load: rsp_rdata = mem_rdata.
  - Byte load: rsp_rdata = zero-extended mem_rdata[15:8] if addr[0]=1, else zero-extended [7:0].
  - Store: rsp_rdata = 0.
- RESP: rsp_valid=1. When rsp_ready=1, go to IDLE.
- Strobes and address stay constant from assertion until mem_resp; the memory contract forbids withdrawing a request.
- flush in IDLE: no effect.
- flush in PTR or ACCESS: set the kill flag. The outstanding access completes, no further levels are issued, and the FSM returns to IDLE on that mem_resp without entering RESP.
- flush in RESP: rsp_valid drops next cycle and the FSM goes to IDLE.
- mem_resp outside PTR/ACCESS is ignored.
- stall_cycles increments each cycle in PTR or ACCESS and saturates at all-ones. It is never cleared except by reset.

## Timing
- All outputs are registered or decoded from state registers. There are no combinational paths from mem_resp or mem_rdata to outputs.
- Reset (rst_n=0, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, mem_read=mem_write=0, mem_wmask=2'b00, mem_address=mem_wdata=0, rsp_rdata=rsp_addr=0, stall_cycles=0, kill=0.
- Reset mid-operation aborts immediately. Memory-side cleanup is the system's responsibility.
- Latency with single-cycle memory: request accepted at cycle N; strobe asserted at N+1. Each level plus the final access costs (memory latency) cycles, plus 1 cycle per state transition. rsp_valid rises the cycle after the final mem_resp.
  - Example: LDI with single-cycle mem_resp gives rsp_valid at N+3.
- A flush arriving in the same cycle as mem_resp takes effect: no RESP entry and no next level.
- A new request is accepted in the cycle after RESP handshakes. There is no IDLE bypass.

## Structure
- Add to lc3b_types:
  - mem_seq_state_t enum {IDLE, PTR, ACCESS, RESP}.
  - lc3b_mem_req struct {write, byte, levels, addr, wdata}, parametrised by use widths.
- Sub-module byte_lane_unit (combinational), used in the ACCESS and capture paths:
  - Inputs: addr[0], byte, wdata, rdata.
  - Outputs: wmask, replicated wdata, extracted rdata.

## Test plan
- Word load, levels=0, addr=0x1234, mem returns 0xBEEF after 3 cycles -> mem_address=0x1234, mem_read held 3 cycles; rsp_rdata=0xBEEF, rsp_addr=0x1234.
- Byte store, addr=0x2001, wdata=0x00A5 -> mem_wmask=2'b10, mem_wdata=0xA5A5, mem_write until mem_resp; rsp_valid then RESP handshake.
- LDI (levels=1), addr=0x3000, ptr read returns 0x4002, final returns 0x1111 -> second read at 0x4002; rsp_rdata=0x1111, rsp_addr=0x4002.
- MAX_INDIRECT=3, levels=3, byte load with final address 0x5003 and mem_rdata=0x7F80 -> three PTR reads, then rsp_rdata=0x007F; a requested levels value above 3 is clamped to 3.
- flush asserted mid-PTR with mem_resp 2 cycles later -> no further access issued, rsp_valid never asserts, req_ready=1 the next cycle.
- rsp_ready held low 5 cycles; rst_n pulsed low during ACCESS -> rsp_rdata stable while waiting; all outputs are at reset values within the reset cycle; stall_cycles saturates at 0xFFFF with CNT_W=16 forced near max.

Source files
------------

// File: rtl/mem_access_sequencer_pkg.sv
// mem_access_sequencer_pkg: shared state encoding and lane constants for the data-port sequencer
package mem_access_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, PTR, ACCESS, RESP} mem_seq_state_t;
  localparam logic [1:0] WMASK_NONE = 2'b00;
  localparam logic [1:0] WMASK_WORD = 2'b11;
endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: byte-lane mask, store-data replication and load-data extraction
module byte_lane_unit #(
  parameter int DATA_W = 16
) (
  input  logic              addr0,
  input  logic              byte_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [1:0]        wmask,
  output logic [DATA_W-1:0] wdata_out,
  output logic [DATA_W-1:0] rdata_out
);
  // byte accesses select one lane by addr0; word accesses use both lanes untouched
  always_comb begin
    wmask     = byte_en ? (addr0 ? 2'b10 : 2'b01) : 2'b11;
    wdata_out = byte_en ? DATA_W'({wdata[7:0], wdata[7:0]}) : wdata;
    rdata_out = byte_en ? DATA_W'(addr0 ? rdata[15:8] : rdata[7:0]) : rdata;
  end
endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: memory-stage data-port sequencer with pointer indirection, flush and stall counting
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int MAX_INDIRECT = 1,
  parameter int CNT_W        = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic                              req_byte,
  input  logic [$clog2(MAX_INDIRECT+1)-1:0] req_levels,
  input  logic [DATA_W-1:0]                 req_addr,
  input  logic [DATA_W-1:0]                 req_wdata,
  input  logic                              flush,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [DATA_W-1:0]                 rsp_rdata,
  output logic [DATA_W-1:0]                 rsp_addr,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [1:0]                        mem_wmask,
  output logic [DATA_W-1:0]                 mem_address,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic                              mem_resp,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output logic [CNT_W-1:0]                  stall_cycles
);
  localparam int LW = $clog2(MAX_INDIRECT+1);
  typedef struct packed {
    logic              write;
    logic              is_byte;
    logic [LW-1:0]     levels;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } lc3b_mem_req;
  mem_seq_state_t    state_q, state_d;
  lc3b_mem_req       req_q, req_d;
  logic              kill_q, kill_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d, rsp_addr_q, rsp_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LW-1:0]     lv;
  logic              busy, killed;
  logic [1:0]        lane_wmask;
  logic [DATA_W-1:0] lane_wdata, lane_rdata, word_addr;
  byte_lane_unit #(.DATA_W(DATA_W)) u_lane (
    .addr0     (req_q.addr[0]),
    .byte_en   (req_q.is_byte),
    .wdata     (req_q.wdata),
    .rdata     (mem_rdata),
    .wmask     (lane_wmask),
    .wdata_out (lane_wdata),
    .rdata_out (lane_rdata)
  );
  // request decode and data-port outputs, all derived from registered state
  always_comb begin
    lv           = (req_levels > LW'(MAX_INDIRECT)) ? LW'(MAX_INDIRECT) : req_levels;
    busy         = (state_q == PTR) || (state_q == ACCESS);
    killed       = kill_q || flush;
    word_addr    = {req_q.addr[DATA_W-1:1], 1'b0};
    req_ready    = state_q == IDLE;
    rsp_valid    = state_q == RESP;
    mem_read     = (state_q == PTR) || (state_q == ACCESS && !req_q.write);
    mem_write    = state_q == ACCESS && req_q.write;
    mem_wmask    = state_q == PTR ? WMASK_WORD : state_q == ACCESS ? lane_wmask : WMASK_NONE;
    mem_address  = state_q == PTR ? word_addr :
                   state_q == ACCESS ? (req_q.is_byte ? req_q.addr : word_addr) : '0;
    mem_wdata    = state_q == ACCESS ? lane_wdata : '0;
    rsp_rdata    = rsp_rdata_q;
    rsp_addr     = rsp_addr_q;
    stall_cycles = cnt_q;
  end
  // next-state: a killed request finishes its outstanding access then drops back to IDLE
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    kill_d      = kill_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_addr_d  = rsp_addr_q;
    cnt_d       = (busy && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (req_valid) begin
          req_d   = '{write: req_write, is_byte: req_byte, levels: lv, addr: req_addr, wdata: req_wdata};
          state_d = (lv != '0) ? PTR : ACCESS;
        end
      end
      PTR: begin
        kill_d = killed;
        if (mem_resp) begin
          req_d.addr   = mem_rdata;
          req_d.levels = req_q.levels - LW'(1);
          state_d      = killed ? IDLE : (req_q.levels == LW'(1)) ? ACCESS : PTR;
        end
      end
      ACCESS: begin
        kill_d = killed;
        if (mem_resp) begin
          state_d = killed ? IDLE : RESP;
          if (!killed) begin
            rsp_rdata_d = req_q.write ? '0 : lane_rdata;
            rsp_addr_d  = req_q.addr;
          end
        end
      end
      RESP: state_d = (flush || rsp_ready) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      kill_q      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      kill_q      <= kill_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_addr_q  <= rsp_addr_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: randomized self-checking bench with a memory responder and reference model
module tb_mem_access_sequencer;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n = 0, req_valid = 0, req_write = 0, req_byte = 0, flush = 0, rsp_ready = 0, mem_resp;
  logic [1:0] req_levels = 0;
  logic [15:0] req_addr = 0, req_wdata = 0, mem_rdata;
  logic req_ready, rsp_valid, mem_read, mem_write;
  logic [1:0] mem_wmask;
  logic [15:0] rsp_rdata, rsp_addr, mem_address, mem_wdata, stall_cycles;
  logic req_ready2, rsp_valid2, mem_read2, mem_write2;
  logic [1:0] mem_wmask2;
  logic [15:0] rsp_rdata2, rsp_addr2, mem_address2, mem_wdata2;
  logic [3:0] stall2;

  mem_access_sequencer #(.DATA_W(16), .MAX_INDIRECT(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_levels(req_levels), .req_addr(req_addr), .req_wdata(req_wdata),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_addr(rsp_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .stall_cycles(stall_cycles));

  mem_access_sequencer #(.DATA_W(16), .MAX_INDIRECT(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2), .req_write(req_write),
    .req_byte(req_byte), .req_levels(req_levels), .req_addr(req_addr), .req_wdata(req_wdata),
    .flush(flush), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata2),
    .rsp_addr(rsp_addr2), .mem_read(mem_read2), .mem_write(mem_write2), .mem_wmask(mem_wmask2),
    .mem_address(mem_address2), .mem_wdata(mem_wdata2), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .stall_cycles(stall2));

  typedef struct {logic rd; logic wr; logic [1:0] mask; logic [15:0] addr; logic [15:0] wdata; int lat;} acc_t;
  acc_t seen[$];
  logic [15:0] mem_init [logic [15:0]];
  int checks = 0, errors = 0, fixed_lat = 1, unstable = 0, exp_stall = 0;
  bit resp_en = 1;

  function automatic logic [15:0] memval(input logic [15:0] a);
    logic [15:0] k;
    k = {a[15:1], 1'b0};
    return mem_init.exists(k) ? mem_init[k] : ((k ^ 16'hA5C3) * 16'd40503) + 16'h1357;
  endfunction

  function automatic int sum_lat();
    int s = 0;
    foreach (seen[i]) s += seen[i].lat;
    return s;
  endfunction

  // memory responder: fixed or random latency, records each completed access
  initial begin : responder
    int wcnt;
    int cur_lat;
    acc_t snap;
    wcnt = 0;
    cur_lat = 1;
    mem_resp = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_resp = 0;
      mem_rdata = 16'($urandom);
      if (!rst_n) wcnt = 0;
      else if (mem_read || mem_write) begin
        if (wcnt == 0) begin
          cur_lat = fixed_lat > 0 ? fixed_lat : int'($urandom_range(1, 3));
          snap = '{mem_read, mem_write, mem_wmask, mem_address, mem_wdata, 0};
        end else if (snap.rd !== mem_read || snap.wr !== mem_write || snap.mask !== mem_wmask ||
                     snap.addr !== mem_address || snap.wdata !== mem_wdata) unstable++;
        wcnt++;
        if (resp_en && wcnt >= cur_lat) begin
          mem_resp = 1;
          mem_rdata = memval(mem_address);
          snap.lat = wcnt;
          seen.push_back(snap);
          wcnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic w, input logic b, input logic [1:0] lv, input logic [15:0] a, input logic [15:0] wd);
    seen.delete();
    @(negedge clk);
    req_valid = 1; req_write = w; req_byte = b; req_levels = lv; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_rsp(output int cyc, output bit to);
    cyc = 1;
    while (!rsp_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    to = !rsp_valid;
  endtask

  task automatic complete(input int hold);
    repeat (hold) @(negedge clk);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, mem_read, mem_write, mem_wmask} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl got %b want 100000", {req_ready, rsp_valid, mem_read, mem_write, mem_wmask});
    end
    checks++;
    if (mem_address !== 0 || mem_wdata !== 0 || rsp_rdata !== 0 || rsp_addr !== 0 || stall_cycles !== 0) begin
      errors++; $display("FAIL reset_data got addr=%h wd=%h rd=%h ra=%h st=%h want all 0", mem_address, mem_wdata, rsp_rdata, rsp_addr, stall_cycles);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1 || req_ready2 !== 1 || rsp_valid2 !== 0) begin
      errors++; $display("FAIL reset_release got ready=%b ready2=%b valid2=%b want 1 1 0", req_ready, req_ready2, rsp_valid2);
    end
  endtask

  task automatic test_word_load();
    int cyc; bit to;
    mem_init[16'h1234] = 16'hBEEF;
    fixed_lat = 3;
    issue(0, 0, 0, 16'h1234, 16'h0);
    checks++;
    if (mem_read !== 1 || mem_write !== 0 || mem_address !== 16'h1234 || mem_wmask !== 2'b11) begin
      errors++; $display("FAIL word_strobe got rd=%b wr=%b addr=%h mask=%b want 1 0 1234 11", mem_read, mem_write, mem_address, mem_wmask);
    end
    wait_rsp(cyc, to);
    checks++;
    if (to || cyc != 4) begin errors++; $display("FAIL word_latency got %0d want 4", cyc); end
    checks++;
    if (rsp_rdata !== 16'hBEEF || rsp_addr !== 16'h1234) begin
      errors++; $display("FAIL word_rsp got %h@%h want beef@1234", rsp_rdata, rsp_addr);
    end
    checks++;
    if (seen.size() != 1 || seen[0].lat != 3) begin errors++; $display("FAIL word_hold got n=%0d want 1 access held 3", seen.size()); end
    complete(0);
    checks++;
    if (req_ready !== 1 || rsp_valid !== 0) begin errors++; $display("FAIL word_idle got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
    exp_stall += sum_lat();
  endtask

  task automatic test_byte_store();
    int cyc; bit to;
    fixed_lat = 2;
    issue(1, 1, 0, 16'h2001, 16'h00A5);
    checks++;
    if (mem_write !== 1 || mem_read !== 0 || mem_wmask !== 2'b10 || mem_wdata !== 16'hA5A5 || mem_address !== 16'h2001) begin
      errors++; $display("FAIL bstore_strobe got wr=%b rd=%b mask=%b wd=%h addr=%h want 1 0 10 a5a5 2001", mem_write, mem_read, mem_wmask, mem_wdata, mem_address);
    end
    wait_rsp(cyc, to);
    checks++;
    if (to || cyc != 3 || rsp_rdata !== 16'h0 || rsp_addr !== 16'h2001) begin
      errors++; $display("FAIL bstore_rsp got cyc=%0d rd=%h ra=%h want 3 0000 2001", cyc, rsp_rdata, rsp_addr);
    end
    complete(1);
    checks++;
    if (rsp_valid !== 0 || stall_cycles !== 16'(exp_stall + sum_lat())) begin
      errors++; $display("FAIL bstore_stall got valid=%b st=%0d want 0 %0d", rsp_valid, stall_cycles, exp_stall + sum_lat());
    end
    exp_stall += sum_lat();
  endtask

  task automatic test_ldi();
    int cyc; bit to;
    mem_init[16'h3000] = 16'h4002;
    mem_init[16'h4002] = 16'h1111;
    fixed_lat = 1;
    issue(0, 0, 1, 16'h3000, 16'h0);
    wait_rsp(cyc, to);
    checks++;
    if (to || cyc != 3) begin errors++; $display("FAIL ldi_latency got %0d want 3", cyc); end
    checks++;
    if (seen.size() != 2 || seen[0].addr !== 16'h3000 || seen[1].addr !== 16'h4002 || !seen[1].rd) begin
      errors++; $display("FAIL ldi_seq got n=%0d want reads 3000 then 4002", seen.size());
    end
    checks++;
    if (rsp_rdata !== 16'h1111 || rsp_addr !== 16'h4002) begin errors++; $display("FAIL ldi_rsp got %h@%h want 1111@4002", rsp_rdata, rsp_addr); end
    complete(0);
    exp_stall += sum_lat();
  endtask

  task automatic test_multi_level();
    int cyc; bit to;
    mem_init[16'h6000] = 16'h6100;
    mem_init[16'h6100] = 16'h6200;
    mem_init[16'h6200] = 16'h5003;
    mem_init[16'h5002] = 16'h7F80;
    fixed_lat = 0;
    issue(0, 1, 3, 16'h6000, 16'h0);
    wait_rsp(cyc, to);
    checks++;
    if (to || cyc != 1 + sum_lat()) begin errors++; $display("FAIL multi_latency got %0d want %0d", cyc, 1 + sum_lat()); end
    checks++;
    if (seen.size() != 4 || seen[0].addr !== 16'h6000 || seen[1].addr !== 16'h6100 || seen[2].addr !== 16'h6200 ||
        seen[3].addr !== 16'h5003 || seen[3].mask !== 2'b10) begin
      errors++; $display("FAIL multi_seq got n=%0d want 6000 6100 6200 5003/10", seen.size());
    end
    checks++;
    if (rsp_rdata !== 16'h007F || rsp_addr !== 16'h5003) begin errors++; $display("FAIL multi_rsp got %h@%h want 007f@5003", rsp_rdata, rsp_addr); end
    checks++;
    if (rsp_valid2 !== 1 || rsp_addr2 !== 16'h6200 || rsp_rdata2 !== 16'h0003) begin
      errors++; $display("FAIL clamp_rsp got v=%b %h@%h want 1 0003@6200", rsp_valid2, rsp_rdata2, rsp_addr2);
    end
    complete(0);
    exp_stall += sum_lat();
  endtask

  task automatic test_backpressure();
    int cyc; bit to;
    logic [15:0] a, r0;
    fixed_lat = 2;
    a = 16'($urandom);
    issue(0, 0, 0, a, 16'h0);
    wait_rsp(cyc, to);
    r0 = rsp_rdata;
    checks++;
    if (to || r0 !== memval(a)) begin errors++; $display("FAIL bp_data got %h want %h", r0, memval(a)); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1 || rsp_rdata !== r0) begin errors++; $display("FAIL bp_hold got v=%b %h want 1 %h", rsp_valid, rsp_rdata, r0); end
    end
    complete(0);
    exp_stall += sum_lat();
  endtask

  task automatic test_flush_ptr();
    fixed_lat = 3;
    issue(0, 0, 1, 16'h3000, 16'h0);
    flush = 1;
    @(negedge clk);
    flush = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1 || rsp_valid !== 0 || mem_read !== 0) begin
      errors++; $display("FAIL flush_ptr_idle got ready=%b valid=%b rd=%b want 1 0 0", req_ready, rsp_valid, mem_read);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (seen.size() != 1 || rsp_valid !== 0) begin errors++; $display("FAIL flush_ptr_accesses got %0d want 1", seen.size()); end
    exp_stall += sum_lat();
  endtask

  task automatic test_flush_same_cycle();
    fixed_lat = 1;
    for (int lv = 0; lv < 2; lv++) begin
      issue(0, 0, 2'(lv), 16'h3000, 16'h0);
      flush = 1;
      @(negedge clk);
      flush = 0;
      checks++;
      if (req_ready !== 1 || rsp_valid !== 0) begin
        errors++; $display("FAIL flush_same lv=%0d got ready=%b valid=%b want 1 0", lv, req_ready, rsp_valid);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (seen.size() != 1 || rsp_valid !== 0) begin errors++; $display("FAIL flush_same_n lv=%0d got %0d want 1", lv, seen.size()); end
      exp_stall += sum_lat();
    end
  endtask

  task automatic test_flush_resp();
    int cyc; bit to;
    fixed_lat = 1;
    issue(0, 0, 0, 16'h1234, 16'h0);
    wait_rsp(cyc, to);
    flush = 1;
    @(negedge clk);
    flush = 0;
    checks++;
    if (to || rsp_valid !== 0 || req_ready !== 1) begin errors++; $display("FAIL flush_resp got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
    exp_stall += sum_lat();
  endtask

  task automatic test_random();
    int cyc; bit to;
    logic w, b;
    logic [1:0] lv;
    logic [15:0] a, wd, mv, erd, eaddr;
    acc_t exp_q[$];
    fixed_lat = 0;
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom); b = 1'($urandom); lv = 2'($urandom_range(0, 3));
      a = 16'($urandom); wd = 16'($urandom);
      exp_q.delete();
      eaddr = a;
      for (int i = 0; i < lv; i++) begin
        exp_q.push_back('{1'b1, 1'b0, 2'b11, {eaddr[15:1], 1'b0}, 16'h0, 0});
        eaddr = memval(eaddr);
      end
      mv = memval(eaddr);
      erd = w ? 16'h0 : b ? (eaddr[0] ? {8'h0, mv[15:8]} : {8'h0, mv[7:0]}) : mv;
      exp_q.push_back('{!w, w, b ? (eaddr[0] ? 2'b10 : 2'b01) : 2'b11,
                        b ? eaddr : {eaddr[15:1], 1'b0}, b ? {wd[7:0], wd[7:0]} : wd, 0});
      issue(w, b, lv, a, wd);
      wait_rsp(cyc, to);
      checks++;
      if (to || cyc != 1 + sum_lat()) begin errors++; $display("FAIL rnd_latency n=%0d got %0d want %0d", n, cyc, 1 + sum_lat()); end
      checks++;
      if (rsp_rdata !== erd || rsp_addr !== eaddr) begin
        errors++; $display("FAIL rnd_rsp n=%0d got %h@%h want %h@%h", n, rsp_rdata, rsp_addr, erd, eaddr);
      end
      checks++;
      if (seen.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count n=%0d got %0d want %0d", n, seen.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= seen.size() || seen[i].rd !== exp_q[i].rd || seen[i].wr !== exp_q[i].wr || seen[i].mask !== exp_q[i].mask ||
            seen[i].addr !== exp_q[i].addr || (exp_q[i].wr && seen[i].wdata !== exp_q[i].wdata)) begin
          errors++; $display("FAIL rnd_access n=%0d i=%0d want rd=%b wr=%b mask=%b addr=%h wd=%h", n, i,
                             exp_q[i].rd, exp_q[i].wr, exp_q[i].mask, exp_q[i].addr, exp_q[i].wdata);
        end
      end
      complete($urandom_range(0, 2));
      exp_stall += sum_lat();
      checks++;
      if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL rnd_stall n=%0d got %0d want %0d", n, stall_cycles, exp_stall); end
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL strobe_stability got %0d changes want 0", unstable); end
  endtask

  task automatic test_reset_mid();
    resp_en = 0;
    fixed_lat = 1;
    issue(1, 0, 0, 16'h0ABC, 16'h5555);
    @(negedge clk);
    checks++;
    if (mem_write !== 1) begin errors++; $display("FAIL rmid_access got wr=%b want 1", mem_write); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, mem_read, mem_write, mem_wmask} !== 6'b100000 || mem_address !== 0 || mem_wdata !== 0 ||
        rsp_rdata !== 0 || rsp_addr !== 0 || stall_cycles !== 0 || stall2 !== 0) begin
      errors++; $display("FAIL rmid_reset got ctl=%b addr=%h wd=%h rd=%h ra=%h st=%0d want reset values",
                         {req_ready, rsp_valid, mem_read, mem_write, mem_wmask}, mem_address, mem_wdata, rsp_rdata, rsp_addr, stall_cycles);
    end
    @(negedge clk);
    rst_n = 1;
    resp_en = 1;
    exp_stall = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1 || mem_write !== 0) begin errors++; $display("FAIL rmid_idle got ready=%b wr=%b want 1 0", req_ready, mem_write); end
  endtask

  task automatic test_saturation();
    int cyc; bit to;
    resp_en = 0;
    fixed_lat = 1;
    issue(0, 0, 0, 16'h0100, 16'h0);
    repeat (14) @(negedge clk);
    checks++;
    if (stall_cycles !== 16'd14 || stall2 !== 4'd14) begin errors++; $display("FAIL sat_pre got %0d/%0d want 14/14", stall_cycles, stall2); end
    repeat (6) @(negedge clk);
    checks++;
    if (stall_cycles !== 16'd20 || stall2 !== 4'hF) begin errors++; $display("FAIL sat_max got %0d/%0d want 20/15", stall_cycles, stall2); end
    resp_en = 1;
    wait_rsp(cyc, to);
    complete(0);
    exp_stall = sum_lat();
    checks++;
    if (to || stall_cycles !== 16'(exp_stall) || stall2 !== 4'hF) begin
      errors++; $display("FAIL sat_end got %0d/%0d want %0d/15", stall_cycles, stall2, exp_stall);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_ldi();
    test_multi_level();
    test_backpressure();
    test_flush_ptr();
    test_flush_same_cycle();
    test_flush_resp();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
